axi4lite_cmd_master: RTL and testbench
======================================

# axi4lite_cmd_master

AXI4-Lite master sequencer that turns single-word read/write commands from a local control client into AXI4-Lite transactions toward `axi4lite_slave` (6-bit address, 32-bit data), one transaction at a time. It sits between on-chip control logic and the slave register block. It owns the AW/W/B/AR/R handshakes, aligns addresses and returns one response pulse per command. It also keeps a saturating count of error write responses.

## Interface

- DATA_WIDTH, 32, data width of command, response and AXI data buses
- ADDR_WIDTH, 6, byte address width of command and AXI address buses
- s_axi_aclk  in  1  single clock; all logic on rising edge
- s_axi_aresetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted on cmd_valid&&cmd_ready
- cmd_write  in  1  1 = write, 0 = read; sampled at accept
- cmd_addr  in  ADDR_WIDTH  byte address; sampled at accept
- cmd_wdata  in  DATA_WIDTH  write data; sampled at accept
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP for writes, 2'b00 for reads (slave has no RRESP)
- err_count  out  8  saturating count of write responses with bresp != 2'b00
- m_axi_awaddr  out  ADDR_WIDTH  write address, bits [1:0] forced 0
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  DATA_WIDTH  write data
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- m_axi_araddr  out  ADDR_WIDTH  read address, bits [1:0] forced 0
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready

## Operation

- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA. Reset state is IDLE.
- IDLE: cmd_ready=1. On accept, latch the command, clear cmd_ready, then go to WADDR (write) or RADDR (read). Drive awaddr/araddr = {cmd_addr[ADDR_WIDTH-1:2],2'b00}.
- WADDR: assert awvalid and wvalid together. Track each handshake independently. Drop a valid the cycle after its own handshake; same-cycle handshakes are allowed. Go to WRESP once both are done.
- WRESP: bready=1. On bvalid: pulse rsp_valid, set rsp_resp=bresp and rsp_rdata=0, and increment err_count if bresp!=00 (saturate at 255). Return to IDLE.
- RADDR: arvalid=1 until arready, then RDATA. RDATA: rready=1. On rvalid: pulse rsp_valid, set rsp_rdata=rdata and rsp_resp=00. Return to IDLE.
- AXI valids never deassert before their handshake. Address and data stay stable while valid is high.
- cmd_valid while busy is ignored. Each accepted command yields exactly one rsp_valid pulse.

## Timing

- All outputs are registered. During reset every output is 0, including cmd_ready and err_count.
- Reset release: cmd_ready=1 from the first rising edge after deassertion.
- Accept at edge 0: AXI valid high from edge 0 to edge 1. With an always-ready slave, the address handshake is at edge 1 and bready/rready is high from edge 1.
- B/R handshake at edge K: rsp_valid high for exactly edge K to edge K+1, and cmd_ready=1 in the same cycle. Best case, write and read complete in 3 cycles.
- Reset asserted mid-transaction: all valids, readies and rsp_valid drop to 0 immediately (async). The in-flight command is discarded and err_count clears.

## Test plan

- Write 0x0C←0xDEADBEEF, slave always ready → awaddr=0x0C, wdata=0xDEADBEEF, one rsp_valid pulse with rsp_resp=00, err_count=0.
- Read 0x0C after that write → araddr=0x0C, rsp_rdata=0xDEADBEEF, rsp_resp=00, one pulse.
- Write with awready delayed 3 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held 3 cycles with stable awaddr, single response.
- Write to 0x0F with bench forcing bresp=10 → awaddr=0x0C, rsp_resp=10, err_count=1. After 256 such writes, err_count=255.
- Reset asserted while in RDATA → rready and rsp_valid are 0 before the next edge. cmd_ready=1 at the first edge after release; err_count=0.
- cmd_valid held high for 20 cycles with a 4-cycle slave latency → exactly one transaction per cmd_ready window; no AW/AR issued while busy.

Source files
------------

// File: rtl/axi4lite_cmd_master_if.sv
// Bundle for the axi4lite_cmd_master block.
// Carries the local command/response channel and the AXI4-Lite master bus.
// The master modport is the sequencer's view; the slave modport is the view
// of whatever drives commands and models the AXI slave.
interface axi4lite_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  // local command / response side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic [7:0]            err_count;

  // AXI4-Lite master side
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready, m_axi_rdata, m_axi_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, err_count,
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, err_count,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axi4lite_cmd_master.sv
// AXI4-Lite command sequencer.
// Accepts one single-word read or write command at a time from a local client,
// runs the matching AXI4-Lite transaction with word-aligned addresses, and
// returns exactly one response pulse per command. Error write responses are
// counted in a saturating 8-bit counter. Every output is a flop.
module axi4lite_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axi4lite_cmd_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } state_t;

  // Clear the two byte-offset bits so every access is word aligned.
  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr);
    return addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  state_t                state_r;
  logic                  aw_done_r;
  logic                  w_done_r;
  logic                  cmd_ready_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic [1:0]            rsp_resp_r;
  logic [7:0]            err_count_r;
  logic [ADDR_WIDTH-1:0] awaddr_r;
  logic                  awvalid_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  wvalid_r;
  logic                  bready_r;
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic                  arvalid_r;
  logic                  rready_r;

  logic aw_hs_s;
  logic w_hs_s;

  assign aw_hs_s = awvalid_r & bus.m_axi_awready;
  assign w_hs_s  = wvalid_r & bus.m_axi_wready;

  assign bus.cmd_ready     = cmd_ready_r;
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_rdata     = rsp_rdata_r;
  assign bus.rsp_resp      = rsp_resp_r;
  assign bus.err_count     = err_count_r;
  assign bus.m_axi_awaddr  = awaddr_r;
  assign bus.m_axi_awvalid = awvalid_r;
  assign bus.m_axi_wdata   = wdata_r;
  assign bus.m_axi_wvalid  = wvalid_r;
  assign bus.m_axi_bready  = bready_r;
  assign bus.m_axi_araddr  = araddr_r;
  assign bus.m_axi_arvalid = arvalid_r;
  assign bus.m_axi_rready  = rready_r;

  // Transaction sequencer: state, AXI handshakes, response pulse and error count.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_r     <= IDLE;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= 2'b00;
      err_count_r <= 8'd0;
      awaddr_r    <= {ADDR_WIDTH{1'b0}};
      awvalid_r   <= 1'b0;
      wdata_r     <= {DATA_WIDTH{1'b0}};
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      araddr_r    <= {ADDR_WIDTH{1'b0}};
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
    end else begin
      // the response pulse lasts exactly one cycle
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            if (bus.cmd_write) begin
              awaddr_r  <= align_addr(bus.cmd_addr);
              wdata_r   <= bus.cmd_wdata;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              aw_done_r <= 1'b0;
              w_done_r  <= 1'b0;
              state_r   <= WADDR;
            end else begin
              araddr_r  <= align_addr(bus.cmd_addr);
              arvalid_r <= 1'b1;
              state_r   <= RADDR;
            end
          end else begin
            // also brings cmd_ready up on the first edge after reset
            cmd_ready_r <= 1'b1;
          end
        end
        WADDR: begin
          // each valid drops right after its own handshake
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
          end
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bready_r  <= 1'b1;
            state_r   <= WRESP;
          end else begin
            aw_done_r <= aw_done_r | aw_hs_s;
            w_done_r  <= w_done_r | w_hs_s;
          end
        end
        WRESP: begin
          if (bus.m_axi_bvalid) begin
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_resp_r  <= bus.m_axi_bresp;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            if (bus.m_axi_bresp != 2'b00) begin
              err_count_r <= sat_inc(err_count_r);
            end
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        RADDR: begin
          if (arvalid_r && bus.m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RDATA;
          end
        end
        RDATA: begin
          if (bus.m_axi_rvalid) begin
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= bus.m_axi_rdata;
            rsp_resp_r  <= 2'b00;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          // unreachable encoding: quiesce the bus and fall back to idle
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          aw_done_r   <= 1'b0;
          w_done_r    <= 1'b0;
          cmd_ready_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed bench for axi4lite_cmd_master with a small behavioural AXI4-Lite
// slave whose per-channel ready/valid latency and write response are set by
// the test tasks.
module tb_axi4lite_cmd_master;

  logic clk = 1'b0;
  logic rst_n;

  axi4lite_cmd_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  axi4lite_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int pass_n  = 0;
  int total_n = 0;

  // slave configuration (cycles a valid waits before ready / response)
  int aw_wait = 0;
  int w_wait  = 0;
  int ar_wait = 0;
  int b_wait  = 0;
  int r_wait  = 0;
  logic [1:0] force_bresp = 2'b00;

  // monitor counters and captures
  int aw_hs_n = 0;
  int w_hs_n  = 0;
  int ar_hs_n = 0;
  int rsp_n   = 0;
  int acc_n   = 0;
  int awv_cycles = 0;
  logic [5:0]  last_awaddr = 6'h0;
  logic [31:0] last_wdata  = 32'h0;
  logic [5:0]  last_araddr = 6'h0;
  logic [1:0]  last_rsp_resp = 2'b00;

  // slave state
  int aw_cnt = 0;
  int w_cnt  = 0;
  int ar_cnt = 0;
  int b_cnt  = 0;
  int r_cnt  = 0;
  int b_issue = 0;
  int r_issue = 0;
  logic [31:0] mem [16];

  // Monitor: counts handshakes, accepts and response pulses at the active edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.m_axi_awvalid) awv_cycles <= awv_cycles + 1;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_hs_n <= aw_hs_n + 1;
        last_awaddr <= bus.m_axi_awaddr;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_hs_n <= w_hs_n + 1;
        last_wdata <= bus.m_axi_wdata;
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_hs_n <= ar_hs_n + 1;
        last_araddr <= bus.m_axi_araddr;
      end
      if (bus.rsp_valid) begin
        rsp_n <= rsp_n + 1;
        last_rsp_resp <= bus.rsp_resp;
      end
      if (bus.cmd_valid && bus.cmd_ready) acc_n <= acc_n + 1;
    end
  end

  // Slave model: drives readies and responses on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.m_axi_awready <= 1'b0;
      bus.m_axi_wready  <= 1'b0;
      bus.m_axi_arready <= 1'b0;
      bus.m_axi_bvalid  <= 1'b0;
      bus.m_axi_rvalid  <= 1'b0;
      bus.m_axi_bresp   <= 2'b00;
      bus.m_axi_rdata   <= 32'h0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      b_issue <= aw_hs_n;
      r_issue <= ar_hs_n;
    end else begin
      if (bus.m_axi_awready) begin
        bus.m_axi_awready <= 1'b0; aw_cnt <= 0;
      end else if (bus.m_axi_awvalid) begin
        if (aw_cnt >= aw_wait) bus.m_axi_awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (bus.m_axi_wready) begin
        bus.m_axi_wready <= 1'b0; w_cnt <= 0;
      end else if (bus.m_axi_wvalid) begin
        if (w_cnt >= w_wait) bus.m_axi_wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      if (bus.m_axi_arready) begin
        bus.m_axi_arready <= 1'b0; ar_cnt <= 0;
      end else if (bus.m_axi_arvalid) begin
        if (ar_cnt >= ar_wait) bus.m_axi_arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end
      if (bus.m_axi_bvalid) begin
        bus.m_axi_bvalid <= 1'b0; b_cnt <= 0;
      end else if (aw_hs_n > b_issue && w_hs_n > b_issue) begin
        if (b_cnt >= b_wait) begin
          bus.m_axi_bvalid <= 1'b1;
          bus.m_axi_bresp  <= force_bresp;
          if (force_bresp == 2'b00) mem[last_awaddr[5:2]] <= last_wdata;
          b_issue <= b_issue + 1;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (bus.m_axi_rvalid) begin
        bus.m_axi_rvalid <= 1'b0; r_cnt <= 0;
      end else if (ar_hs_n > r_issue) begin
        if (r_cnt >= r_wait) begin
          bus.m_axi_rvalid <= 1'b1;
          bus.m_axi_rdata  <= mem[last_araddr[5:2]];
          r_issue <= r_issue + 1;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
    end
  end

  // Present one command; returns at the falling edge after it was accepted.
  task automatic issue_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d, output bit ok);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until the response count passes base.
  task automatic wait_rsp(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_n > base) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 6'h0;
    bus.cmd_wdata = 32'h0;
    repeat (3) @(negedge clk);
    total_n++; if (bus.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); else pass_n++;
    total_n++; if (bus.err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", bus.err_count); else pass_n++;
    total_n++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready, bus.rsp_valid} !== 6'b0)
      $display("FAIL reset_axi_ctrl: got %b want 000000",
               {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready, bus.rsp_valid});
    else pass_n++;
    rst_n = 1'b1;
    #1;
    total_n++; if (bus.cmd_ready !== 1'b0) $display("FAIL release_before_edge: got %b want 0", bus.cmd_ready); else pass_n++;
    @(posedge clk); #1;
    total_n++; if (bus.cmd_ready !== 1'b1) $display("FAIL release_first_edge: got %b want 1", bus.cmd_ready); else pass_n++;
  endtask

  task automatic test_write();
    bit ok;
    int r0 = rsp_n;
    issue_cmd(1'b1, 6'h0C, 32'hDEADBEEF, ok);
    total_n++; if (ok !== 1'b1) $display("FAIL wr_accept: got %b want 1", ok); else pass_n++;
    total_n++; if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b11) $display("FAIL wr_valids: got %b want 11", {bus.m_axi_awvalid, bus.m_axi_wvalid}); else pass_n++;
    total_n++; if (bus.m_axi_awaddr !== 6'h0C) $display("FAIL wr_awaddr: got %h want 0c", bus.m_axi_awaddr); else pass_n++;
    total_n++; if (bus.m_axi_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata: got %h want deadbeef", bus.m_axi_wdata); else pass_n++;
    total_n++; if (bus.cmd_ready !== 1'b0) $display("FAIL wr_busy: got %b want 0", bus.cmd_ready); else pass_n++;
    @(negedge clk);
    total_n++; if ({bus.m_axi_bready, bus.rsp_valid} !== 2'b10) $display("FAIL wr_bready: got %b want 10", {bus.m_axi_bready, bus.rsp_valid}); else pass_n++;
    @(negedge clk);
    total_n++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b11) $display("FAIL wr_rsp_pulse: got %b want 11", {bus.rsp_valid, bus.cmd_ready}); else pass_n++;
    total_n++; if (bus.rsp_resp !== 2'b00) $display("FAIL wr_rsp_resp: got %b want 00", bus.rsp_resp); else pass_n++;
    total_n++; if (bus.rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata: got %h want 0", bus.rsp_rdata); else pass_n++;
    @(negedge clk);
    total_n++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_rsp_one_cycle: got %b want 0", bus.rsp_valid); else pass_n++;
    total_n++; if ((rsp_n - r0) !== 1) $display("FAIL wr_rsp_count: got %0d want 1", rsp_n - r0); else pass_n++;
    total_n++; if (bus.err_count !== 8'd0) $display("FAIL wr_err_count: got %0d want 0", bus.err_count); else pass_n++;
  endtask

  task automatic test_read();
    bit ok;
    int r0 = rsp_n;
    issue_cmd(1'b0, 6'h0C, 32'h0, ok);
    total_n++; if (ok !== 1'b1) $display("FAIL rd_accept: got %b want 1", ok); else pass_n++;
    total_n++; if ({bus.m_axi_arvalid, bus.m_axi_awvalid} !== 2'b10) $display("FAIL rd_arvalid: got %b want 10", {bus.m_axi_arvalid, bus.m_axi_awvalid}); else pass_n++;
    total_n++; if (bus.m_axi_araddr !== 6'h0C) $display("FAIL rd_araddr: got %h want 0c", bus.m_axi_araddr); else pass_n++;
    @(negedge clk);
    total_n++; if ({bus.m_axi_rready, bus.m_axi_arvalid} !== 2'b10) $display("FAIL rd_rready: got %b want 10", {bus.m_axi_rready, bus.m_axi_arvalid}); else pass_n++;
    @(negedge clk);
    total_n++; if (bus.rsp_valid !== 1'b1) $display("FAIL rd_rsp_pulse: got %b want 1", bus.rsp_valid); else pass_n++;
    total_n++; if (bus.rsp_rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h want deadbeef", bus.rsp_rdata); else pass_n++;
    total_n++; if (bus.rsp_resp !== 2'b00) $display("FAIL rd_resp: got %b want 00", bus.rsp_resp); else pass_n++;
    @(negedge clk);
    total_n++; if ((rsp_n - r0) !== 1) $display("FAIL rd_rsp_count: got %0d want 1", rsp_n - r0); else pass_n++;
  endtask

  task automatic test_aw_delay();
    bit ok;
    int r0 = rsp_n;
    int a0 = aw_hs_n;
    int v0 = awv_cycles;
    aw_wait = 2;
    issue_cmd(1'b1, 6'h20, 32'h12345678, ok);
    total_n++; if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b11) $display("FAIL awd_start: got %b want 11", {bus.m_axi_awvalid, bus.m_axi_wvalid}); else pass_n++;
    @(negedge clk);
    total_n++; if ({bus.m_axi_awvalid, bus.m_axi_wvalid} !== 2'b10) $display("FAIL awd_wvalid_drop: got %b want 10", {bus.m_axi_awvalid, bus.m_axi_wvalid}); else pass_n++;
    total_n++; if (bus.m_axi_awaddr !== 6'h20) $display("FAIL awd_addr_c1: got %h want 20", bus.m_axi_awaddr); else pass_n++;
    @(negedge clk);
    total_n++; if ({bus.m_axi_awvalid, bus.m_axi_bready} !== 2'b10) $display("FAIL awd_hold_c2: got %b want 10", {bus.m_axi_awvalid, bus.m_axi_bready}); else pass_n++;
    total_n++; if (bus.m_axi_awaddr !== 6'h20) $display("FAIL awd_addr_c2: got %h want 20", bus.m_axi_awaddr); else pass_n++;
    @(negedge clk);
    total_n++; if ({bus.m_axi_awvalid, bus.m_axi_bready} !== 2'b01) $display("FAIL awd_to_wresp: got %b want 01", {bus.m_axi_awvalid, bus.m_axi_bready}); else pass_n++;
    wait_rsp(r0, ok);
    @(negedge clk);
    total_n++; if ((rsp_n - r0) !== 1) $display("FAIL awd_rsp_count: got %0d want 1", rsp_n - r0); else pass_n++;
    total_n++; if ((awv_cycles - v0) !== 3) $display("FAIL awd_awvalid_cycles: got %0d want 3", awv_cycles - v0); else pass_n++;
    total_n++; if ((aw_hs_n - a0) !== 1) $display("FAIL awd_aw_count: got %0d want 1", aw_hs_n - a0); else pass_n++;
    aw_wait = 0;
  endtask

  task automatic test_bresp_err();
    bit ok;
    int bad = 0;
    int r0 = rsp_n;
    force_bresp = 2'b10;
    issue_cmd(1'b1, 6'h0F, 32'h00000055, ok);
    wait_rsp(r0, ok);
    total_n++; if (ok !== 1'b1) $display("FAIL err_rsp_seen: got %b want 1", ok); else pass_n++;
    total_n++; if (last_awaddr !== 6'h0C) $display("FAIL err_awaddr_aligned: got %h want 0c", last_awaddr); else pass_n++;
    total_n++; if (last_rsp_resp !== 2'b10) $display("FAIL err_rsp_resp: got %b want 10", last_rsp_resp); else pass_n++;
    total_n++; if (bus.err_count !== 8'd1) $display("FAIL err_count_1: got %0d want 1", bus.err_count); else pass_n++;
    for (int i = 0; i < 255; i++) begin
      r0 = rsp_n;
      issue_cmd(1'b1, 6'h0F, 32'h00000055, ok);
      if (!ok) bad++;
      wait_rsp(r0, ok);
      if (!ok) bad++;
    end
    total_n++; if (bad !== 0) $display("FAIL err_loop_timeouts: got %0d want 0", bad); else pass_n++;
    total_n++; if (bus.err_count !== 8'd255) $display("FAIL err_count_255: got %0d want 255", bus.err_count); else pass_n++;
    r0 = rsp_n;
    issue_cmd(1'b1, 6'h0F, 32'h00000055, ok);
    wait_rsp(r0, ok);
    total_n++; if (bus.err_count !== 8'd255) $display("FAIL err_count_saturate: got %0d want 255", bus.err_count); else pass_n++;
    force_bresp = 2'b00;
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    int acc0 = acc_n;
    int aw0 = aw_hs_n;
    int ar0 = ar_hs_n;
    int r0 = rsp_n;
    aw_wait = 3; w_wait = 3; b_wait = 3;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 6'h10;
    bus.cmd_wdata = 32'hA5A5A5A5;
    repeat (20) @(negedge clk);
    bus.cmd_valid = 1'b0;
    total_n++; if ((acc_n - acc0) !== 3) $display("FAIL b2b_accepts: got %0d want 3", acc_n - acc0); else pass_n++;
    for (int i = 0; i < 100; i++) begin
      if ((rsp_n - r0) >= 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total_n++; if (ok !== 1'b1) $display("FAIL b2b_drain: got %b want 1", ok); else pass_n++;
    total_n++; if ((rsp_n - r0) !== 3) $display("FAIL b2b_rsp_count: got %0d want 3", rsp_n - r0); else pass_n++;
    total_n++; if ((aw_hs_n - aw0) !== 3) $display("FAIL b2b_aw_count: got %0d want 3", aw_hs_n - aw0); else pass_n++;
    total_n++; if ((ar_hs_n - ar0) !== 0) $display("FAIL b2b_ar_count: got %0d want 0", ar_hs_n - ar0); else pass_n++;
    aw_wait = 0; w_wait = 0; b_wait = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    int r0;
    r_wait = 5;
    issue_cmd(1'b0, 6'h0C, 32'h0, ok);
    for (int i = 0; i < 20; i++) begin
      if (bus.m_axi_rready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_n++; if (seen !== 1'b1) $display("FAIL rst_reach_rdata: got %b want 1", seen); else pass_n++;
    #2;
    rst_n = 1'b0;
    #1;
    total_n++; if ({bus.m_axi_rready, bus.rsp_valid, bus.cmd_ready} !== 3'b000) $display("FAIL rst_async_drop: got %b want 000", {bus.m_axi_rready, bus.rsp_valid, bus.cmd_ready}); else pass_n++;
    total_n++; if (bus.err_count !== 8'd0) $display("FAIL rst_err_clear: got %0d want 0", bus.err_count); else pass_n++;
    repeat (3) @(negedge clk);
    r_wait = 0;
    r0 = rsp_n;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_n++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); else pass_n++;
    total_n++; if (bus.err_count !== 8'd0) $display("FAIL rst_release_err: got %0d want 0", bus.err_count); else pass_n++;
    repeat (10) @(negedge clk);
    total_n++; if ((rsp_n - r0) !== 0) $display("FAIL rst_no_stale_rsp: got %0d want 0", rsp_n - r0); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_aw_delay();
    test_bresp_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_n, total_n);
    $fatal(1);
  end

endmodule
